reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 117 +++++++++++
 tb/tb_reset_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Ordered reset release for NUM_STAGES downstream domains: hold all resets
// after clock lock, then release them one by one and raise done_o.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lock_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  done_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_STAGES-1:0] REL_NONE  = NUM_STAGES'(0);
  localparam logic [NUM_STAGES-1:0] REL_FIRST = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] REL_ALL   = {NUM_STAGES{1'b1}};

  // ST_ASSERT is the all-zero code so that an all-zero register file is the reset state
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rel_q, rel_d;
  logic [NUM_STAGES-1:0]   rel_next_s;
  logic                    done_q, done_d;
  logic                    abort_s;

  // Next-state logic: abort overrides everything, otherwise walk the sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    done_d     = done_q;
    abort_s    = rst_i | ~lock_i | sw_rst_req_i;
    // Released mask grows from bit 0 upward, so a released stage always has its predecessor released
    rel_next_s = (rel_q << 1) | REL_FIRST;

    if (abort_s) begin
      state_d = ST_ASSERT;
      cnt_d   = CNT_ZERO;
      rel_d   = REL_NONE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
          rel_d   = REL_NONE;
          done_d  = 1'b0;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = CNT_ZERO;
            rel_d   = REL_FIRST;
            state_d = (NUM_STAGES == 1) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = CNT_ZERO;
            rel_d   = rel_next_s;
            state_d = (rel_next_s == REL_ALL) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          cnt_d  = CNT_ZERO;
          rel_d  = REL_ALL;
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_ZERO;
          rel_d   = REL_NONE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= CNT_ZERO;
      rel_q   <= REL_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
    end
  end

  // Resets are stored as a released mask; zero mask means every domain held
  assign rst_o  = ~rel_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default build plus a 1/1/1 build,
// both driven by the same directed and random abort stimulus.
module tb_reset_sequencer;

  localparam int N0 = 3, H0 = 16, G0 = 4;
  localparam int N1 = 1, H1 = 1,  G1 = 1;

  logic clk = 1'b0;
  logic rst_i, lock_i, sw_rst_req_i;
  logic [N0-1:0] rst_o0;
  logic          done_o0;
  logic [N1-1:0] rst_o1;
  logic          done_o1;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int t_start = -1;

  typedef struct {
    logic [7:0] rst;
    logic       done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(N0), .HOLD_CYCLES(H0), .STAGE_GAP(G0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .sw_rst_req_i(sw_rst_req_i),
    .rst_o(rst_o0), .done_o(done_o0)
  );

  reset_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .sw_rst_req_i(sw_rst_req_i),
    .rst_o(rst_o1), .done_o(done_o1)
  );

  // Expected outputs from the elapsed cycles since the clean start edge t
  function automatic exp_t model(int t, int e, int n, int h, int g);
    exp_t r;
    int k;
    r.rst  = 8'h00;
    r.done = 1'b0;
    if (t < 0) begin
      for (int i = 0; i < n; i++) r.rst[i] = 1'b1;
    end else begin
      k = e - t;
      for (int i = 0; i < n; i++) r.rst[i] = (k < h + i * g) ? 1'b1 : 1'b0;
      r.done = (k >= h + (n - 1) * g + 1) ? 1'b1 : 1'b0;
    end
    return r;
  endfunction

  // Reference: any abort sampled clears the start; first clean edge afterwards starts the sequence
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst_i || !lock_i || sw_rst_req_i) t_start = -1;
    else if (t_start < 0) t_start = edge_n;
    q0.push_back(model(t_start, edge_n, N0, H0, G0));
    q1.push_back(model(t_start, edge_n, N1, H1, G1));
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_n, act, exp);
    end
  endtask

  task automatic check_order(string name, logic [7:0] v, int n);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < n; k++) if (v[k] === 1'b0 && v[k-1] !== 1'b0) ok = 1'b0;
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("FAIL %s edge=%0d got=%b expected=higher bits released only after lower", name, edge_n, v);
    end
  endtask

  // Monitor: compare each edge's outputs half a cycle later
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0_rst",  {5'b0, rst_o0}, e.rst);
      check("dut0_done", {7'b0, done_o0}, {7'b0, e.done});
      check_order("dut0_order", {5'b0, rst_o0}, N0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1_rst",  {7'b0, rst_o1}, e.rst);
      check("dut1_done", {7'b0, done_o1}, {7'b0, e.done});
    end
  end

  task automatic drive(logic r, logic l, logic s, int n);
    @(negedge clk);
    rst_i = r;
    lock_i = l;
    sw_rst_req_i = s;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int pct;
    rst_i = 1'b1;
    lock_i = 1'b1;
    sw_rst_req_i = 1'b0;
    repeat (4) @(negedge clk);
    // Nominal release to DONE
    drive(1'b0, 1'b1, 1'b0, 35);
    // Single-cycle software request while in DONE
    drive(1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1'b0, 35);
    // Held software request
    drive(1'b0, 1'b1, 1'b1, 6);
    drive(1'b0, 1'b1, 1'b0, 21);
    // One-cycle lock glitch mid-release, then full redo
    drive(1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 40);
    // One-cycle reset pulse during RELEASE
    drive(1'b1, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 19);
    drive(1'b1, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 35);
    // Late lock from reset
    drive(1'b1, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0, 9);
    drive(1'b0, 1'b1, 1'b0, 40);
    // Random aborts at varying density
    for (int blk = 0; blk < 20; blk++) begin
      pct = (blk % 2 == 0) ? 1 : 4;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        rst_i        = ($urandom_range(0, 199) < pct) ? 1'b1 : 1'b0;
        lock_i       = ($urandom_range(0, 199) < pct) ? 1'b0 : 1'b1;
        sw_rst_req_i = ($urandom_range(0, 199) < pct) ? 1'b1 : 1'b0;
      end
    end
    drive(1'b0, 1'b1, 1'b0, 40);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
